pipe_mem_arbiter: RTL
=====================

Name: pipe_mem_arbiter

Overview:
- Sequences the single Avalon-style memory port shared by the pipeline's instruction-fetch (IF) stage and data-access (MEM) stage.
- Grants one requester at a time, registers the bus command and holds it through waitrequest.
- Returns read data with a one-cycle done pulse, and drives stall signals back to the pipeline control.
- Sits between the IF/MEM stage logic and the external memory bus.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive MEM grants while IF is waiting before IF is forced a grant; legal range 1..15.
- TIMEOUT_CYCLES, 64: waitrequest watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous reset, active low
- if_req  in  1  IF read request; held with if_addr until if_done
- if_addr  in  32  IF read address
- if_done  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  32  fetched instruction word
- if_stall  out  1  if_req high and if_done low (combinational)
- mem_req  in  1  MEM access request; held until mem_done
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_byteenable  in  4  store/load byte lanes
- mem_done  out  1  one-cycle pulse; completion of read or write
- mem_rdata  out  32  load data, valid with mem_done on reads
- mem_stall  out  1  mem_req high and mem_done low (combinational)
- address  out  32  bus address
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- writedata  out  32  bus write data
- byteenable  out  4  bus byte lanes; 4'b1111 for IF
- readdata  in  32  bus read data, valid when read high and waitrequest low
- waitrequest  in  1  bus busy; command must be held while high
- bus_error  out  1  sticky timeout flag; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset: reset_n low at a rising edge puts the FSM in IDLE and clears starve_cnt.
  - address, writedata, byteenable, if_rdata, mem_rdata, bus_error reset to 0.
  - read, write, if_done, mem_done reset to 0.
- FSM states: IDLE, BUS_IF, BUS_MEM.
- IDLE grant rules, evaluated each cycle:
  - If mem_req and not (if_req and starve_cnt == STARVE_LIMIT): go to BUS_MEM and latch mem_addr, mem_wdata, mem_byteenable and mem_we into the bus registers.
  - Else if if_req: go to BUS_IF, latch if_addr, byteenable = 4'b1111, read = 1.
  - Else stay in IDLE with read = write = 0.
- Bus command timing: the registered bus command appears the cycle after the grant decision and is held unchanged while waitrequest = 1.
- Completion: in a BUS_* state with waitrequest = 0, the transaction completes that cycle.
  - Next edge: read and write go to 0, the FSM returns to IDLE, and the matching done pulses high for exactly 1 cycle.
  - On reads, readdata is captured into if_rdata or mem_rdata at the same edge.
  - rdata holds its value until the next completion for that requester.
- Minimum latency: request in cycle N, bus strobe in N+1 (waitrequest low), done in N+2. A new grant can be made in the done cycle (IDLE), so sustained throughput is 1 access per 2 cycles at zero wait.
- starve_cnt (4-bit):
  - Increments on each MEM grant made while if_req = 1, saturating at STARVE_LIMIT.
  - Clears on each IF grant.
  - Unchanged otherwise.
- Simultaneous if_req and mem_req: MEM wins unless the starvation limit has been reached.
- Requests: a request deasserted after its grant does not abort the transaction; the done pulse still fires. Requesters must hold their inputs stable until done, but the arbiter depends only on the values latched at grant.
- Strobes: read and write are never both 1.
- Idle bus: address and writedata keep their last values while idle.
- Reset mid-transaction: the strobes drop at that edge and the transaction is dropped with no done pulse. The bus is expected to tolerate abandoned commands.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A wait counter clears on each grant and increments each BUS_* cycle with waitrequest = 1.
  - On reaching TIMEOUT_CYCLES, the transaction is abandoned: strobes drop, the FSM returns to IDLE, and the requester's done pulses with rdata = 32'hDEADBEEF.
  - bus_error sets and remains 1 until reset.
- When undefined: no counter, waiting is unbounded, and bus_error is tied 0.

Test Plan:
- IF-only read at if_addr 0xBFC00000, readdata 0x24020005, waitrequest 0 -> read high at cycle N+1 with address 0xBFC00000 and byteenable 0xF; if_done pulse at N+2 with if_rdata 0x24020005; if_stall high in N and N+1 only.
- if_req and mem_req (write 0x11223344 to 0x100, byteenable 0x3) in the same cycle -> write issued first with writedata 0x11223344 and byteenable 0x3, mem_done pulses; IF read then granted in the mem_done cycle, if_done two cycles later.
- MEM read with waitrequest high for 3 cycles, readdata 0xCAFEF00D -> address and read held constant for 4 cycles; mem_done pulse the cycle after waitrequest falls with mem_rdata 0xCAFEF00D.
- STARVE_LIMIT = 2, mem_req and if_req held continuously -> grant order MEM, MEM, IF, MEM, MEM, IF.
- reset_n driven low while BUS_MEM is waiting -> read/write 0 at that edge, no mem_done, FSM IDLE; after release, a pending if_req is granted normally.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and waitrequest stuck high -> after 8 wait cycles the strobes drop, mem_done pulses with mem_rdata 0xDEADBEEF, and bus_error is 1 and stays 1.

Source files
------------

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one Avalon-style memory port between the IF and MEM
// pipeline stages. A grant latches the requester's command into the bus
// registers and holds it through waitrequest. Completion pulses the matching
// done for one cycle and captures read data.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   if_req/if_addr                IF read request (held until if_done)
//   if_done/if_rdata/if_stall     IF completion pulse, fetched word, stall
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_byteenable      MEM access request (held until mem_done)
//   mem_done/mem_rdata/mem_stall  MEM completion pulse, load data, stall
//   address/read/write/
//   writedata/byteenable          registered bus command
//   readdata/waitrequest          bus response
//   bus_error                     sticky waitrequest-timeout flag
//
// Optional feature: define ARB_TIMEOUT_EN to add a waitrequest watchdog of
// TIMEOUT_CYCLES; a stuck transaction is abandoned with rdata 32'hDEADBEEF
// and bus_error set. Without it bus_error is tied 0.
module pipe_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byteenable,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        bus_error
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  starve_cnt, starve_d;
  logic [31:0]       address_d, writedata_d, if_rdata_d, mem_rdata_d;
  logic [3:0]        byteenable_d;
  logic              read_d, write_d, if_done_d, mem_done_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic              error_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign bus_error      = 1'b0;
`endif

  // Stalls are combinational so the pipeline freezes in the request cycle.
  assign if_stall  = if_req  & ~if_done;
  assign mem_stall = mem_req & ~mem_done;

  // Next-state, grant and bus command logic.
  always_comb begin
    state_d      = state;
    starve_d     = starve_cnt;
    address_d    = address;
    writedata_d  = writedata;
    byteenable_d = byteenable;
    read_d       = read;
    write_d      = write;
    if_rdata_d   = if_rdata;
    mem_rdata_d  = mem_rdata;
    if_done_d    = 1'b0;
    mem_done_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wait_d       = wait_cnt;
    error_d      = bus_error;
`endif
    case (state)
      IDLE: begin
        read_d  = 1'b0;
        write_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wait_d  = '0;
`endif
        // MEM has priority unless IF has been passed over STARVE_LIMIT times.
        if (mem_req && !(if_req && starve_cnt == STARVE_MAX)) begin
          state_d      = BUS_MEM;
          address_d    = mem_addr;
          writedata_d  = mem_wdata;
          byteenable_d = mem_byteenable;
          read_d       = ~mem_we;
          write_d      = mem_we;
          if (if_req && starve_cnt != STARVE_MAX) begin
            starve_d = starve_cnt + CNT_W'(1);
          end
        end else if (if_req) begin
          state_d      = BUS_IF;
          address_d    = if_addr;
          byteenable_d = 4'b1111;
          read_d       = 1'b1;
          starve_d     = '0;
        end
      end
      BUS_IF: begin
        if (!waitrequest) begin
          state_d    = IDLE;
          read_d     = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = readdata;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = IDLE;
          read_d     = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = TIMEOUT_DATA;
          error_d    = 1'b1;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
`endif
      end
      BUS_MEM: begin
        if (!waitrequest) begin
          state_d    = IDLE;
          read_d     = 1'b0;
          write_d    = 1'b0;
          mem_done_d = 1'b1;
          if (read) begin
            mem_rdata_d = readdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          read_d      = 1'b0;
          write_d     = 1'b0;
          mem_done_d  = 1'b1;
          mem_rdata_d = TIMEOUT_DATA;
          error_d     = 1'b1;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_done    <= 1'b0;
      mem_done   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      bus_error  <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      starve_cnt <= starve_d;
      address    <= address_d;
      writedata  <= writedata_d;
      byteenable <= byteenable_d;
      read       <= read_d;
      write      <= write_d;
      if_rdata   <= if_rdata_d;
      mem_rdata  <= mem_rdata_d;
      if_done    <= if_done_d;
      mem_done   <= mem_done_d;
`ifdef ARB_TIMEOUT_EN
      wait_cnt   <= wait_d;
      bus_error  <= error_d;
`endif
    end
  end

endmodule
